uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the UART TX FIFO among three sensor/timer report sources (stopwatch, DHT11, SR04). It latches a 12-bit value per source on request, picks one pending source, converts its value to four ASCII decimal digits, and pushes a framed message byte-by-byte into the TX FIFO, honouring its `full` flag. It sits between the measurement blocks and the TX FIFO push port, replacing direct per-source push logic.

## Interface
Parameters:
- `TAG0`, default 8'h53 ('S'): frame tag for channel 0.
- `TAG1`, default 8'h54 ('T'): frame tag for channel 1.
- `TAG2`, default 8'h44 ('D'): frame tag for channel 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  3  per-channel send request, one-cycle pulse.
- `data0`, `data1`, `data2`  in  12 each  value to report, sampled when the matching `req` bit is high.
- `fifo_full`  in  1  TX FIFO full flag.
- `push`  out  1  FIFO push strobe, one cycle per byte.
- `push_data`  out  8  byte to push, valid when `push`=1.
- `grant`  out  3  one-hot channel being served; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last byte of a frame is pushed.

## Operation
- Per channel: 12-bit hold register and pending bit. `req[i]`=1 loads `data_i` into hold[i] and sets pending[i]. A repeated request while pending overwrites hold[i]; only one frame is produced.
- States: IDLE, CONV, SEND, DONE.
- IDLE: if any pending bit is set, select a channel round-robin, starting at `rr_ptr`. Load hold[sel] into the conversion register. Clear pending[sel], set `grant`, go to CONV.
- If `req[sel]` is high on the grant edge, pending[sel] stays set and hold[sel] takes the new value. The snapshot already captured keeps the old value.
- CONV: double-dabble binary-to-BCD, exactly 12 cycles, then go to SEND. Range 0..4095 gives 4 digits. Leading zeros are kept.
- SEND: byte index 0..6 = TAG, d3, d2, d1, d0 (each digit + 8'h30), 8'h0D, 8'h0A.
  - In any cycle with `fifo_full`=0: `push`=1, `push_data` = current byte, index increments.
  - In any cycle with `fifo_full`=1: `push`=0 and the index holds.
- After the push of the last byte, go to DONE.
- DONE (1 cycle): `done`=1. `rr_ptr` ← (sel+1) mod 3. `grant` ← 0. Go to IDLE.
- `rr_ptr` resets to 0, so channel 0 has top priority first.
- The hold registers stay writable in every state.
- Reset mid-frame: all state, pending bits and hold registers clear immediately, and the partial frame is abandoned. Bytes already pushed are not recalled.

## Timing
- Reset values: `push`=0, `push_data`=8'h00, `grant`=3'b000, `busy`=0, `done`=0, `rr_ptr`=0, pending=0, hold=0.
- All outputs are registered.
- From `req` sampled at edge k:
  - pending is set after edge k.
  - Grant happens at edge k+1.
  - CONV covers edges k+2..k+13.
  - The first `push` is high in the cycle after edge k+13, if the FIFO is not full.
- With no backpressure, 7 pushes occur on consecutive cycles. `done` follows the cycle after the last push.
- IDLE → next grant: 1 cycle after DONE, so frames are separated by one IDLE cycle.
- `push_data` changes only when it is pushed or when a new frame starts.

## Configuration
- `UART_SCHED_CHKSUM_EN` defined:
  - The frame is 8 bytes: TAG, d3..d0, CHK, 8'h0D, 8'h0A.
  - CHK = XOR of TAG and the four ASCII digit bytes.
  - The index runs 0..7.
- Not defined: the 7-byte frame as above, with no checksum logic.

## Test plan
- Reset, then `req`=3'b001 with `data0`=1234 and `fifo_full`=0 → pushes 53 31 32 33 34 0D 0A on 7 consecutive cycles. The first push is 14 cycles after `req`. `done` pulses once and `grant` returns to 0.
- After reset, `req`=3'b111 with data 0 / 4095 / 42 → frames in order:
  - ch0: 53 30 30 30 30 0D 0A
  - ch1: 54 34 30 39 35 0D 0A
  - ch2: 44 30 30 34 32 0D 0A
- Fairness: serve ch1 alone, then pulse `req`=3'b111 → service order ch2, ch0, ch1.
- Backpressure: hold `fifo_full`=1 for 5 cycles after the 3rd push → no push while full, and `push_data` holds 8'h32. The remaining 4 bytes follow when full drops, with no loss or duplication.
- Re-request: pulse `req[0]` with 100 during ch0 CONV of 7 → the frame for 0007 completes, then a second frame with 0100 follows.
- Reset asserted mid-SEND (after byte 2) → all outputs go to reset values immediately. No further pushes occur, and the next request produces a full frame from TAG. With `UART_SCHED_CHKSUM_EN` and 1234 on ch0, CHK = 8'h57.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler sharing one UART TX FIFO among three report
//   sources. Each source latches a 12-bit value on a request pulse. The
//   scheduler picks one pending source, converts its value to four ASCII
//   decimal digits (double-dabble, 12 cycles) and pushes a framed message
//   into the FIFO one byte per cycle, stalling while the FIFO is full.
//
//   Frame: TAG d3 d2 d1 d0 [CHK] CR LF
//   CHK is present only when UART_SCHED_CHKSUM_EN is defined. It is the XOR
//   of TAG and the four ASCII digit bytes.
//
// Parameters
//   TAG0, TAG1, TAG2 : frame tag byte for channel 0 / 1 / 2
// Ports
//   clk       : system clock
//   rst       : asynchronous reset, active-high
//   req[2:0]  : per-channel send request, one-cycle pulse
//   data0..2  : 12-bit value, sampled when the matching req bit is high
//   fifo_full : TX FIFO full flag; a byte is pushed only while it is low
//   push      : FIFO push strobe, one cycle per byte (registered)
//   push_data : byte being pushed (registered)
//   grant     : one-hot channel being served, 0 when idle (registered)
//   busy      : scheduler is serving a frame (registered)
//   done      : one-cycle pulse after the last byte of a frame (registered)
module uart_tx_scheduler #(
  parameter logic [7:0] TAG0 = 8'h53,
  parameter logic [7:0] TAG1 = 8'h54,
  parameter logic [7:0] TAG2 = 8'h44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [11:0] data0,
  input  logic [11:0] data1,
  input  logic [11:0] data2,
  input  logic        fifo_full,
  output logic        push,
  output logic [7:0]  push_data,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

`ifdef UART_SCHED_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  state_t      state;
  logic [11:0] hold [3];
  logic [2:0]  pending;
  logic [2:0]  clr_mask;
  logic [1:0]  rr_ptr;
  logic [1:0]  sel;
  logic [1:0]  pick;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic        grant_now;
  logic [11:0] bin;
  logic [15:0] bcd;
  logic [14:0] bcd_adj;
  logic [3:0]  cnt;
  logic [2:0]  idx;
  logic [7:0]  tag;
  logic [7:0]  a3, a2, a1, a0;
  logic [7:0]  cur_byte;
`ifdef UART_SCHED_CHKSUM_EN
  logic [7:0]  chk;
`endif

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Round-robin pick starting at rr_ptr; a request arriving on the grant
  // edge wins over the pending clear, so that channel is served again.
  always_comb begin
    c1 = nxt(rr_ptr);
    c2 = nxt(c1);
    if (pending[rr_ptr])  pick = rr_ptr;
    else if (pending[c1]) pick = c1;
    else                  pick = c2;
    grant_now = (state == IDLE) && (|pending);
    clr_mask  = grant_now ? (3'b001 << pick) : 3'b000;
  end

  // Add-3 step ahead of each shift. The top digit's bit 3 is shifted out,
  // so only its low three bits are kept (they match the full 4-bit sum).
  always_comb begin
    bcd_adj[14:12] = (bcd[15:12] >= 4'd5) ? (bcd[14:12] + 3'd3) : bcd[14:12];
    bcd_adj[11:0]  = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
  end

  always_comb begin
    case (sel)
      2'd0:    tag = TAG0;
      2'd1:    tag = TAG1;
      default: tag = TAG2;
    endcase
    a3 = 8'h30 + {4'h0, bcd[15:12]};
    a2 = 8'h30 + {4'h0, bcd[11:8]};
    a1 = 8'h30 + {4'h0, bcd[7:4]};
    a0 = 8'h30 + {4'h0, bcd[3:0]};
`ifdef UART_SCHED_CHKSUM_EN
    chk = tag ^ a3 ^ a2 ^ a1 ^ a0;
    case (idx)
      3'd0:    cur_byte = tag;
      3'd1:    cur_byte = a3;
      3'd2:    cur_byte = a2;
      3'd3:    cur_byte = a1;
      3'd4:    cur_byte = a0;
      3'd5:    cur_byte = chk;
      3'd6:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
`else
    case (idx)
      3'd0:    cur_byte = tag;
      3'd1:    cur_byte = a3;
      3'd2:    cur_byte = a2;
      3'd3:    cur_byte = a1;
      3'd4:    cur_byte = a0;
      3'd5:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int unsigned i = 0; i < 3; i++) hold[i] <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      idx       <= '0;
      push      <= 1'b0;
      push_data <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (req[0]) hold[0] <= data0;
      if (req[1]) hold[1] <= data1;
      if (req[2]) hold[2] <= data2;
      pending <= (pending & ~clr_mask) | req;
      push    <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_now) begin
            sel   <= pick;
            grant <= 3'b001 << pick;
            busy  <= 1'b1;
            bin   <= hold[pick];
            bcd   <= '0;
            cnt   <= '0;
            idx   <= '0;
            state <= CONV;
          end
        end
        // The tag byte does not depend on the digits, so it is pushed on the
        // final conversion edge; the digits are complete from the next cycle.
        CONV: begin
          bin <= {bin[10:0], 1'b0};
          bcd <= {bcd_adj, bin[11]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11) begin
            state <= SEND;
            if (!fifo_full) begin
              push      <= 1'b1;
              push_data <= cur_byte;
              idx       <= 3'd1;
            end
          end
        end
        SEND: begin
          if (!fifo_full) begin
            push      <= 1'b1;
            push_data <= cur_byte;
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + 3'd1;
          end
        end
        DONE: begin
          done   <= 1'b1;
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= nxt(sel);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

`ifdef UART_SCHED_CHKSUM_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [11:0] data0 = '0;
  logic [11:0] data1 = '0;
  logic [11:0] data2 = '0;
  logic        fifo_full = 1'b0;
  logic        push;
  logic [7:0]  push_data;
  logic [2:0]  grant;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int dcnt   = 0;
  logic [7:0] q[$];
  int         pc[$];
  logic [2:0] gq[$];

  uart_tx_scheduler #(.TAG0(8'h53), .TAG1(8'h54), .TAG2(8'h44)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .fifo_full(fifo_full), .push(push), .push_data(push_data),
    .grant(grant), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Byte monitor: records every pushed byte with its cycle and grant.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (push) begin
      q.push_back(push_data);
      pc.push_back(cyc);
      gq.push_back(grant);
    end
    if (done) dcnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] tag, input int val, input int i);
    logic [7:0] a3, a2, a1, a0;
    a3 = 8'h30 + 8'(val / 1000);
    a2 = 8'h30 + 8'((val / 100) % 10);
    a1 = 8'h30 + 8'((val / 10) % 10);
    a0 = 8'h30 + 8'(val % 10);
`ifdef UART_SCHED_CHKSUM_EN
    case (i)
      0: return tag;
      1: return a3;
      2: return a2;
      3: return a1;
      4: return a0;
      5: return tag ^ a3 ^ a2 ^ a1 ^ a0;
      6: return 8'h0D;
      default: return 8'h0A;
    endcase
`else
    case (i)
      0: return tag;
      1: return a3;
      2: return a2;
      3: return a1;
      4: return a0;
      5: return 8'h0D;
      default: return 8'h0A;
    endcase
`endif
  endfunction

  function automatic logic [31:0] qb(input int i);
    return (i < q.size()) ? {24'h0, q[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int pcx(input int i);
    return (i < pc.size()) ? pc[i] : -1000;
  endfunction

  function automatic logic [31:0] gx(input int i);
    return (i < gq.size()) ? {29'h0, gq[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic check_frame(input string name, input int base, input logic [7:0] tag, input int val);
    for (int i = 0; i < FL; i++)
      chk($sformatf("%s[%0d]", name, i), qb(base + i), {24'h0, exp_byte(tag, val, i)});
  endtask

  task automatic wait_pushes(input int n, input int budget, input string tag);
    int i = 0;
    while (q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, q.size() >= n, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    logic got = 1'b0;
    while (!got && i < budget) begin
      @(negedge clk);
      i++;
      if (done === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    pc.delete();
    gq.delete();
    dcnt = 0;
  endtask

  // Called at a negedge; leaves the caller at the following negedge.
  task automatic pulse_req(input logic [2:0] m, input int d0, input int d1, input int d2, output int c);
    req = m;
    data0 = 12'(d0);
    data1 = 12'(d1);
    data2 = 12'(d2);
    c = cyc;
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    int c0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_push", push, 0);
    chk("rst_push_data", push_data, 8'h00);
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    q.delete(); pc.delete(); gq.delete(); dcnt = 0;
    @(negedge clk);

    // Single frame, ch0 = 1234
    pulse_req(3'b001, 1234, 0, 0, c0);
    chk("t1_no_grant_yet", grant, 3'b000);
    @(negedge clk);
    chk("t1_grant", grant, 3'b001);
    chk("t1_busy", busy, 1);
    wait_pushes(FL, 40, "t1_pushes");
    chk("t1_first_latency", pcx(0) - c0, 14);
    chk("t1_consecutive", pcx(FL - 1) - pcx(0), FL - 1);
    chk("t1_tag", qb(0), 8'h53);
    chk("t1_d0", qb(4), 8'h34);
`ifdef UART_SCHED_CHKSUM_EN
    chk("t1_chk", qb(5), 8'h57);
`endif
    check_frame("t1", 0, 8'h53, 1234);
    wait_done(10, "t1_done_seen");
    chk("t1_done_cycle", cyc, pcx(FL - 1) + 1);
    chk("t1_grant_idle", grant, 3'b000);
    chk("t1_busy_idle", busy, 0);
    repeat (5) @(negedge clk);
    chk("t1_done_once", dcnt, 1);
    chk("t1_no_extra_push", q.size(), FL);

    // Three simultaneous requests after reset: order 0,1,2
    do_reset();
    pulse_req(3'b111, 0, 4095, 42, c0);
    wait_pushes(3 * FL, 120, "t2_pushes");
    check_frame("t2_ch0", 0, 8'h53, 0);
    check_frame("t2_ch1", FL, 8'h54, 4095);
    check_frame("t2_ch2", 2 * FL, 8'h44, 42);
    chk("t2_g0", gx(0), 3'b001);
    chk("t2_g1", gx(FL), 3'b010);
    chk("t2_g2", gx(2 * FL), 3'b100);
    chk("t2_frame_gap", pcx(FL) - pcx(FL - 1), 14);

    // Fairness: after serving ch1, order is 2,0,1
    do_reset();
    pulse_req(3'b010, 0, 3, 0, c0);
    wait_pushes(FL, 40, "t3_first");
    wait_done(10, "t3_first_done");
    q.delete(); pc.delete(); gq.delete();
    pulse_req(3'b111, 1, 2, 3, c0);
    wait_pushes(3 * FL, 120, "t3_pushes");
    chk("t3_g0", gx(0), 3'b100);
    chk("t3_g1", gx(FL), 3'b001);
    chk("t3_g2", gx(2 * FL), 3'b010);
    check_frame("t3_ch2", 0, 8'h44, 3);
    check_frame("t3_ch0", FL, 8'h53, 1);
    check_frame("t3_ch1", 2 * FL, 8'h54, 2);

    // Backpressure after third push
    do_reset();
    pulse_req(3'b001, 1234, 0, 0, c0);
    wait_pushes(3, 40, "t4_three");
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_push%0d", i), push, 0);
      chk($sformatf("t4_stall_data%0d", i), push_data, 8'h32);
    end
    fifo_full = 1'b0;
    chk("t4_count_held", q.size(), 3);
    wait_pushes(FL, 40, "t4_pushes");
    check_frame("t4", 0, 8'h53, 1234);
    repeat (4) @(negedge clk);
    chk("t4_no_dup", q.size(), FL);

    // Re-request during conversion
    do_reset();
    pulse_req(3'b001, 7, 0, 0, c0);
    repeat (3) @(negedge clk);
    pulse_req(3'b001, 100, 0, 0, c0);
    wait_pushes(2 * FL, 100, "t5_pushes");
    check_frame("t5_a", 0, 8'h53, 7);
    check_frame("t5_b", FL, 8'h53, 100);

    // Request on the grant edge: snapshot keeps old value, new one follows
    do_reset();
    pulse_req(3'b001, 5, 0, 0, c0);
    pulse_req(3'b001, 9, 0, 0, c0);
    wait_pushes(2 * FL, 100, "t6_pushes");
    check_frame("t6_a", 0, 8'h53, 5);
    check_frame("t6_b", FL, 8'h53, 9);

    // Reset in the middle of SEND
    do_reset();
    pulse_req(3'b001, 1234, 0, 0, c0);
    wait_pushes(3, 40, "t7_three");
    rst = 1'b1;
    #1;
    chk("t7_push", push, 0);
    chk("t7_push_data", push_data, 8'h00);
    chk("t7_grant", grant, 3'b000);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t7_abandoned", q.size(), 3);
    pulse_req(3'b001, 1234, 0, 0, c0);
    wait_pushes(3 + FL, 40, "t7_refresh");
    check_frame("t7_new", 3, 8'h53, 1234);
`ifdef UART_SCHED_CHKSUM_EN
    chk("t7_chk", qb(8), 8'h57);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
